mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 94 +++++++++
 tb/tb_mem_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port CPU memory arbiter: round-robin instruction/data reads onto one SRAM read port,
// plus a combinational shared write bus where debug writes always take priority over CPU writes.
module mem_arbiter #(
   parameter logic [15:0] RD_FILL     = 16'hEEEE,
   parameter logic [3:0]  SRAM_REGION = 4'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] ins_rd_addr,
   input  logic        ins_rd_req,
   output logic        ins_rd_rdy,
   output logic [15:0] ins_rd_data,
   input  logic [15:0] dat_rw_addr,
   input  logic        dat_rd_req,
   output logic        dat_rd_rdy,
   output logic [15:0] dat_rd_data,
   input  logic        dat_wr_req,
   input  logic [15:0] dat_wr_data,
   output logic        dat_wr_rdy,
   input  logic        dbg_we,
   input  logic [15:0] dbg_waddr,
   input  logic [15:0] dbg_wdata,
   output logic [15:0] mem_raddr,
   output logic        mem_re,
   input  logic [15:0] mem_rdata,
   output logic [15:0] mem_waddr,
   output logic [15:0] mem_wdata,
   output logic        mem_we
);

   logic        ins_rdy_q, dat_rdy_q, wr_rdy_q, fill_q, last_dat_q;
   logic [15:0] raddr_q, ins_data_q, dat_data_q;
   logic [15:0] raddr_d, ins_data_d, dat_data_d;
   logic        ins_elig, dat_elig, ins_gnt, dat_gnt, wr_gnt, dat_sram;

   // A requester whose rdy is showing is still finishing that transaction, so it is not eligible.
   always_comb begin
      ins_elig = ins_rd_req & ~ins_rdy_q & ~reset;
      dat_elig = dat_rd_req & ~dat_rdy_q & ~reset;
      ins_gnt  = ins_elig & (~dat_elig | last_dat_q);
      dat_gnt  = dat_elig & (~ins_elig | ~last_dat_q);
      dat_sram = (dat_rw_addr[15:12] == SRAM_REGION);
      wr_gnt   = dat_wr_req & ~dbg_we & ~wr_rdy_q & ~reset;
   end

   always_comb begin
      raddr_d = raddr_q;
      if (ins_gnt)
         raddr_d = ins_rd_addr;
      else if (dat_gnt && dat_sram)
         raddr_d = dat_rw_addr;
   end

   assign mem_re    = ins_gnt | (dat_gnt & dat_sram);
   assign mem_raddr = raddr_d;

   assign mem_we    = dbg_we | wr_gnt;
   assign mem_waddr = dbg_we ? dbg_waddr : dat_rw_addr;
   assign mem_wdata = dbg_we ? dbg_wdata : dat_wr_data;

   // Masking with reset drops a pulse owed to a grant made just before reset asserted.
   assign ins_rd_rdy = ins_rdy_q & ~reset;
   assign dat_rd_rdy = dat_rdy_q & ~reset;
   assign dat_wr_rdy = wr_rdy_q  & ~reset;

   assign ins_data_d  = ins_rd_rdy ? mem_rdata : ins_data_q;
   assign dat_data_d  = dat_rd_rdy ? (fill_q ? RD_FILL : mem_rdata) : dat_data_q;
   assign ins_rd_data = ins_data_d;
   assign dat_rd_data = dat_data_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         ins_rdy_q  <= 1'b0;
         dat_rdy_q  <= 1'b0;
         wr_rdy_q   <= 1'b0;
         fill_q     <= 1'b0;
         last_dat_q <= 1'b0;
         raddr_q    <= 16'h0000;
         ins_data_q <= 16'h0000;
         dat_data_q <= 16'h0000;
      end else begin
         ins_rdy_q  <= ins_gnt;
         dat_rdy_q  <= dat_gnt;
         wr_rdy_q   <= wr_gnt;
         fill_q     <= dat_gnt & ~dat_sram;
         if (ins_gnt || dat_gnt)
            last_dat_q <= dat_gnt;
         raddr_q    <= raddr_d;
         ins_data_q <= ins_data_d;
         dat_data_q <= dat_data_d;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a stimulus process queues expected read data and write
// completions, and a negedge monitor pops and checks them whenever a rdy pulse appears.
module tb_mem_arbiter;

   logic        clk, reset;
   logic [15:0] ins_rd_addr, dat_rw_addr, dat_wr_data, dbg_waddr, dbg_wdata;
   logic        ins_rd_req, dat_rd_req, dat_wr_req, dbg_we;
   logic        ins_rd_rdy, dat_rd_rdy, dat_wr_rdy, mem_re, mem_we;
   logic [15:0] ins_rd_data, dat_rd_data, mem_raddr, mem_waddr, mem_wdata;
   logic [15:0] mem_rdata;

   logic [15:0] sram [0:65535];
   logic [15:0] ins_exp[$], dat_exp[$], wr_exp[$];
   int n_cmp = 0;
   int n_err = 0;

   mem_arbiter dut (
      .clk(clk), .reset(reset),
      .ins_rd_addr(ins_rd_addr), .ins_rd_req(ins_rd_req), .ins_rd_rdy(ins_rd_rdy),
      .ins_rd_data(ins_rd_data),
      .dat_rw_addr(dat_rw_addr), .dat_rd_req(dat_rd_req), .dat_rd_rdy(dat_rd_rdy),
      .dat_rd_data(dat_rd_data),
      .dat_wr_req(dat_wr_req), .dat_wr_data(dat_wr_data), .dat_wr_rdy(dat_wr_rdy),
      .dbg_we(dbg_we), .dbg_waddr(dbg_waddr), .dbg_wdata(dbg_wdata),
      .mem_raddr(mem_raddr), .mem_re(mem_re), .mem_rdata(mem_rdata),
      .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_we(mem_we)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM behind the arbiter: 1-cycle read latency, region-0 writes only, read-before-write.
   initial mem_rdata = 16'h0000;
   always @(posedge clk) begin
      if (mem_re) mem_rdata <= sram[mem_raddr];
      if (mem_we && mem_waddr[15:12] == 4'h0) sram[mem_waddr] <= mem_wdata;
   end

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %04h expected %04h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every rdy pulse must match a queued expectation.
   always @(negedge clk) begin
      logic [15:0] e;
      if (ins_rd_rdy) begin
         if (ins_exp.size() == 0) chk1("ins_rdy_unexpected", ins_rd_rdy, 1'b0);
         else begin e = ins_exp.pop_front(); chk16("ins_rd_data", ins_rd_data, e); end
      end
      if (dat_rd_rdy) begin
         if (dat_exp.size() == 0) chk1("dat_rdy_unexpected", dat_rd_rdy, 1'b0);
         else begin e = dat_exp.pop_front(); chk16("dat_rd_data", dat_rd_data, e); end
      end
      if (dat_wr_rdy) begin
         if (wr_exp.size() == 0) chk1("wr_rdy_unexpected", dat_wr_rdy, 1'b0);
         else begin e = wr_exp.pop_front(); chk16("wr_rdy_addr", dat_rw_addr, e); end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [15:0] pa [4];
      logic [15:0] pd [4];
      logic [15:0] ra [4];
      logic        dr [4];
      logic        ir [4];
      pa = '{16'h0010, 16'h0004, 16'h0020, 16'h0040};
      pd = '{16'h1234, 16'hAAAA, 16'hBBBB, 16'h1111};
      ra = '{16'h0004, 16'h0020, 16'h0004, 16'h0020};
      dr = '{1'b0, 1'b1, 1'b0, 1'b1};
      ir = '{1'b0, 1'b0, 1'b1, 1'b0};

      reset = 1'b1;
      ins_rd_addr = '0; ins_rd_req = 0; dat_rw_addr = '0; dat_rd_req = 0;
      dat_wr_req = 0; dat_wr_data = '0; dbg_we = 0; dbg_waddr = '0; dbg_wdata = '0;
      tick(); tick();
      @(negedge clk);
      chk1("rst_ins_rdy", ins_rd_rdy, 1'b0);
      chk1("rst_mem_re", mem_re, 1'b0);
      chk1("rst_mem_we", mem_we, 1'b0);
      chk16("rst_mem_raddr", mem_raddr, 16'h0000);
      chk16("rst_ins_data", ins_rd_data, 16'h0000);
      chk16("rst_dat_data", dat_rd_data, 16'h0000);

      // Preload SRAM through the debug port while reset is held.
      for (int i = 0; i < 4; i++) begin
         tick();
         dbg_we = 1'b1; dbg_waddr = pa[i]; dbg_wdata = pd[i];
         @(negedge clk);
         chk1("rst_dbg_we", mem_we, 1'b1);
         chk16("rst_dbg_waddr", mem_waddr, pa[i]);
      end

      // Instruction read held high with data idle: grant / rdy alternate.
      tick();
      dbg_we = 0; reset = 0; ins_rd_req = 1; ins_rd_addr = 16'h0010;
      repeat (3) ins_exp.push_back(16'h1234);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk1("ins_hold_mem_re", mem_re, 1'(k % 2 == 0));
         chk1("ins_hold_rdy", ins_rd_rdy, 1'(k % 2));
         if (k == 0) chk16("ins_hold_raddr", mem_raddr, 16'h0010);
         tick();
      end
      ins_rd_req = 0;
      @(negedge clk);
      chk1("idle_mem_re", mem_re, 1'b0);
      chk16("idle_raddr_hold", mem_raddr, 16'h0010);

      // Both readers held: data wins first tie, then strict alternation.
      tick();
      dat_rd_req = 1; dat_rw_addr = 16'h0004; ins_rd_req = 1; ins_rd_addr = 16'h0020;
      repeat (2) dat_exp.push_back(16'hAAAA);
      repeat (2) ins_exp.push_back(16'hBBBB);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk1("rr_mem_re", mem_re, 1'b1);
         chk16("rr_raddr", mem_raddr, ra[k]);
         chk1("rr_dat_rdy", dat_rd_rdy, dr[k]);
         chk1("rr_ins_rdy", ins_rd_rdy, ir[k]);
         tick();
      end
      dat_rd_req = 0;
      @(negedge clk);
      chk1("rr_tail_mem_re", mem_re, 1'b0);
      chk1("rr_tail_ins_rdy", ins_rd_rdy, 1'b1);
      tick();
      ins_rd_req = 0;

      // Data read outside SRAM region returns the fill value without an SRAM access.
      dat_rd_req = 1; dat_rw_addr = 16'h8005;
      dat_exp.push_back(16'hEEEE);
      @(negedge clk);
      chk1("fill_mem_re", mem_re, 1'b0);
      tick();
      @(negedge clk);
      chk1("fill_rdy", dat_rd_rdy, 1'b1);
      chk1("fill_mem_re2", mem_re, 1'b0);
      tick();
      dat_rd_req = 0;

      // CPU write blocked by three debug write cycles.
      dat_wr_req = 1; dat_rw_addr = 16'h0030; dat_wr_data = 16'hBEEF;
      wr_exp.push_back(16'h0030);
      for (int k = 0; k < 3; k++) begin
         dbg_we = 1; dbg_waddr = 16'h0100 + 16'(k); dbg_wdata = 16'hD000 + 16'(k);
         @(negedge clk);
         chk1("dbgblk_we", mem_we, 1'b1);
         chk16("dbgblk_waddr", mem_waddr, 16'h0100 + 16'(k));
         chk16("dbgblk_wdata", mem_wdata, 16'hD000 + 16'(k));
         chk1("dbgblk_wr_rdy", dat_wr_rdy, 1'b0);
         tick();
      end
      dbg_we = 0;
      @(negedge clk);
      chk1("cpuwr_we", mem_we, 1'b1);
      chk16("cpuwr_waddr", mem_waddr, 16'h0030);
      chk16("cpuwr_wdata", mem_wdata, 16'hBEEF);
      chk1("cpuwr_rdy_early", dat_wr_rdy, 1'b0);
      tick();
      @(negedge clk);
      chk1("cpuwr_rdy", dat_wr_rdy, 1'b1);
      chk1("cpuwr_no_regrant", mem_we, 1'b0);
      tick();
      dat_wr_req = 0;

      // Reset right after an instruction grant: the pulse is discarded.
      ins_rd_req = 1; ins_rd_addr = 16'h0010;
      @(negedge clk);
      chk1("prerst_mem_re", mem_re, 1'b1);
      tick();
      reset = 1; dbg_we = 1; dbg_waddr = 16'h0050; dbg_wdata = 16'h7777;
      @(negedge clk);
      chk1("rst_drop_rdy", ins_rd_rdy, 1'b0);
      chk1("rst_mem_re_low", mem_re, 1'b0);
      chk1("rst_dbg_pass", mem_we, 1'b1);
      chk16("rst_dbg_wdata", mem_wdata, 16'h7777);
      tick();
      @(negedge clk);
      chk1("rst_drop_rdy2", ins_rd_rdy, 1'b0);
      chk16("rst_raddr_clr", mem_raddr, 16'h0000);
      chk16("rst_ins_data_clr", ins_rd_data, 16'h0000);

      // First cycle after reset: same-cycle write and read to 0x0040 (old data), then re-read.
      tick();
      reset = 0; ins_rd_req = 0; dbg_we = 0;
      dat_wr_req = 1; dat_rd_req = 1; dat_rw_addr = 16'h0040; dat_wr_data = 16'h5555;
      wr_exp.push_back(16'h0040);
      dat_exp.push_back(16'h1111);
      dat_exp.push_back(16'h5555);
      @(negedge clk);
      chk1("post_rst_ins_rdy", ins_rd_rdy, 1'b0);
      chk1("raw_mem_re", mem_re, 1'b1);
      chk1("raw_mem_we", mem_we, 1'b1);
      chk16("raw_raddr", mem_raddr, 16'h0040);
      tick();
      @(negedge clk);
      chk1("raw_rd_rdy", dat_rd_rdy, 1'b1);
      chk1("raw_wr_rdy", dat_wr_rdy, 1'b1);
      chk1("raw_no_regrant", mem_re, 1'b0);
      tick();
      dat_wr_req = 0;
      @(negedge clk);
      chk1("reread_mem_re", mem_re, 1'b1);
      tick();
      @(negedge clk);
      chk1("reread_rdy", dat_rd_rdy, 1'b1);
      tick();
      dat_rd_req = 0;
      @(negedge clk);
      chk16("hold_dat_data", dat_rd_data, 16'h5555);
      tick(); tick(); tick();

      chk16("ins_q_drained", 16'(ins_exp.size()), 16'h0000);
      chk16("dat_q_drained", 16'(dat_exp.size()), 16'h0000);
      chk16("wr_q_drained", 16'(wr_exp.size()), 16'h0000);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
